// File: rtl/usb_rx_deserializer_pkg.sv
// Shared types for the low-speed USB receive path.
//   d_port_t   : retimed line symbol {D+, D-} from the CDR
//   J, K, SE0  : line states (low-speed idle J has D- high)
//   rx_state_t : receive FSM states
package usb_rx_deserializer_pkg;

    typedef logic [1:0] d_port_t;

    localparam d_port_t SE0 = 2'b00;
    localparam d_port_t J   = 2'b01;
    localparam d_port_t K   = 2'b10;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ABORT} rx_state_t;

    localparam int SYNC_MIN_ZEROS_DEF = 5;
    localparam int IDLE_BITS_DEF      = 8;

endpackage

// File: rtl/usb_bit_unstuff.sv
// NRZI decoder and consecutive-ones tracker.
//   clk, reset : system clock, synchronous active-high reset
//   strobe     : one pulse per bit-time; symbol is valid while high
//   symbol     : retimed line symbol
//   clear      : forces the ones counter to zero
//   bit_out    : NRZI-decoded bit for the current symbol (1 = no transition)
//   bit_valid  : strobe with a J/K symbol that is a data bit (not a stuff bit)
//   stuff_err  : strobe where a seventh consecutive 1 arrives
module usb_bit_unstuff
    import usb_rx_deserializer_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    strobe,
    input  d_port_t symbol,
    input  logic    clear,
    output logic    bit_out,
    output logic    bit_valid,
    output logic    stuff_err
);

    d_port_t    prev_q, prev_d;
    logic [2:0] ones_q, ones_d;
    logic       is_jk;
    logic       at_six;

    always_comb begin
        is_jk     = (symbol == J) || (symbol == K);
        bit_out   = (symbol == prev_q);
        at_six    = (ones_q == 3'd6);
        stuff_err = strobe && is_jk && at_six && bit_out;
        // After six ones the next J/K is either the stuff bit or a violation.
        bit_valid = strobe && is_jk && !at_six;
        prev_d    = prev_q;
        ones_d    = ones_q;
        if (strobe && is_jk) begin
            prev_d = symbol;
            if (at_six)       ones_d = 3'd0;
            else if (bit_out) ones_d = ones_q + 3'd1;
            else              ones_d = 3'd0;
        end
        if (clear) ones_d = 3'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= J;
            ones_q <= 3'd0;
        end else begin
            prev_q <= prev_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/usb_rx_deserializer.sv
// Low-speed USB receive stage: SYNC detection, unstuffing, LSB-first byte
// assembly and EOP/abort handling behind the CDR.
//   clk, reset : 24 MHz clock, synchronous active-high reset
//   q, strobe  : retimed symbol and its one-clk per-bit strobe
//   rx_data    : last received byte, held until the next one
//   rx_valid   : one-clk pulse, rx_data holds a new byte
//   rx_active  : high from SYNC completion until EOP or abort exit
//   rx_error   : one-clk pulse on stuff, EOP-alignment or SE0 error
module usb_rx_deserializer
    import usb_rx_deserializer_pkg::*;
#(
    parameter int SYNC_MIN_ZEROS = SYNC_MIN_ZEROS_DEF,
    parameter int IDLE_BITS      = IDLE_BITS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  d_port_t    q,
    input  logic       strobe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_error
);

    localparam int JW = $clog2(IDLE_BITS + 1);

    rx_state_t   state_q, state_d;
    logic [2:0]  zero_cnt_q, zero_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  se0_cnt_q, se0_cnt_d;
    logic [JW-1:0] j_cnt_q, j_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_active_q, rx_active_d;
    logic        rx_error_q, rx_error_d;

    logic dec_bit, bit_valid, stuff_err, unstuff_clear;

    // Holding the ones counter clear in IDLE makes it read 1 right after the
    // SYNC-terminating 1, which is where bit stuffing starts counting.
    assign unstuff_clear = (state_q == IDLE);

    usb_bit_unstuff u_unstuff (
        .clk       (clk),
        .reset     (reset),
        .strobe    (strobe),
        .symbol    (q),
        .clear     (unstuff_clear),
        .bit_out   (dec_bit),
        .bit_valid (bit_valid),
        .stuff_err (stuff_err)
    );

    always_comb begin
        state_d     = state_q;
        zero_cnt_d  = zero_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        se0_cnt_d   = se0_cnt_q;
        j_cnt_d     = j_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_active_d = rx_active_q;
        rx_valid_d  = 1'b0;
        rx_error_d  = 1'b0;
        if (strobe) begin
            unique case (state_q)
                IDLE: if (q == K) begin
                    state_d    = SYNC;
                    zero_cnt_d = 3'd1;
                end
                SYNC: begin
                    if (q == SE0) begin
                        state_d = IDLE;
                    end else if (!dec_bit) begin
                        if (zero_cnt_q != 3'd7) zero_cnt_d = zero_cnt_q + 3'd1;
                    end else if (zero_cnt_q >= 3'(SYNC_MIN_ZEROS)) begin
                        state_d     = DATA;
                        rx_active_d = 1'b1;
                        bit_cnt_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (q == SE0) begin
                        state_d    = EOP;
                        se0_cnt_d  = 2'd1;
                        rx_error_d = (bit_cnt_q != 3'd0);
                    end else if (stuff_err) begin
                        state_d    = ABORT;
                        rx_error_d = 1'b1;
                        se0_cnt_d  = 2'd0;
                        j_cnt_d    = '0;
                    end else if (bit_valid) begin
                        shift_d   = {dec_bit, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = shift_d;
                            rx_valid_d = 1'b1;
                        end
                    end
                end
                EOP: begin
                    if (q == SE0) begin
                        if (se0_cnt_q != 2'd2) se0_cnt_d = se0_cnt_q + 2'd1;
                    end else if (q == J && se0_cnt_q == 2'd2) begin
                        state_d     = IDLE;
                        rx_active_d = 1'b0;
                    end else begin
                        state_d    = ABORT;
                        rx_error_d = 1'b1;
                        se0_cnt_d  = 2'd0;
                        j_cnt_d    = '0;
                    end
                end
                ABORT: begin
                    // se0_cnt remembers whether the previous strobe was SE0.
                    if (q == SE0) begin
                        se0_cnt_d = 2'd1;
                        j_cnt_d   = '0;
                    end else if (q == J) begin
                        se0_cnt_d = 2'd0;
                        if (se0_cnt_q != 2'd0 || j_cnt_q == JW'(IDLE_BITS - 1)) begin
                            state_d     = IDLE;
                            rx_active_d = 1'b0;
                        end else begin
                            j_cnt_d = j_cnt_q + 1'b1;
                        end
                    end else begin
                        se0_cnt_d = 2'd0;
                        j_cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            zero_cnt_q  <= 3'd0;
            bit_cnt_q   <= 3'd0;
            se0_cnt_q   <= 2'd0;
            j_cnt_q     <= '0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_active_q <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_cnt_q  <= zero_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            se0_cnt_q   <= se0_cnt_d;
            j_cnt_q     <= j_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_active_q <= rx_active_d;
            rx_error_q  <= rx_error_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_active = rx_active_q;
    assign rx_error  = rx_error_q;

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Bench for usb_rx_deserializer: a transmitter model builds packets from
// bytes (LSB-first, stuffing after six ones, NRZI), pushes the packet-level
// events it should cause, and a monitor pops them as the DUT reports them.
module tb_usb_rx_deserializer;
    import usb_rx_deserializer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    d_port_t    q;
    logic       strobe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_active, rx_error;

    usb_rx_deserializer dut (
        .clk       (clk),
        .reset     (reset),
        .q         (q),
        .strobe    (strobe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_active (rx_active),
        .rx_error  (rx_error)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_BYTE, EV_ERR, EV_RISE, EV_FALL} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] payload[$];
    int         vectors = 0;
    int         miscompares = 0;
    bit         mon_en = 1'b0;
    logic       act_prev = 1'b0;
    d_port_t    line = J;
    int         ones = 0;

    task automatic push_ev(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got %s data=%02h, required none", k.name(), d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_BYTE && e.data != d)) begin
                miscompares++;
                $display("FAIL event_order: got %s data=%02h, required %s data=%02h",
                         k.name(), d, e.kind.name(), e.data);
            end
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h, required %02h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rx_valid === 1'b1) check_ev(EV_BYTE, rx_data);
            if (rx_error === 1'b1) check_ev(EV_ERR, 8'h00);
            if (rx_active === 1'b1 && act_prev !== 1'b1) check_ev(EV_RISE, 8'h00);
            if (rx_active !== 1'b1 && act_prev === 1'b1) check_ev(EV_FALL, 8'h00);
            act_prev = rx_active;
        end
    end

    // ---- transmitter model ----
    task automatic send_sym(input d_port_t s);
        q      = s;
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        repeat ($urandom_range(4, 1)) begin @(posedge clk); #1; end
    endtask

    task automatic send_line(input d_port_t s);
        if (s != SE0) line = s;
        send_sym(s);
    endtask

    // NRZI: a 0 toggles the line, a 1 holds it.
    task automatic send_bit(input logic b);
        if (!b) line = (line == J) ? K : J;
        send_sym(line);
    endtask

    task automatic data_bit(input logic b);
        send_bit(b);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
            send_bit(1'b0);
            ones = 0;
        end
    endtask

    task automatic data_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) data_bit(v[i]);
    endtask

    task automatic sync_seq(input int nzeros);
        repeat (nzeros) send_bit(1'b0);
        send_bit(1'b1);
        ones = 1;
    endtask

    task automatic eop();
        send_line(SE0);
        send_line(SE0);
        send_line(J);
    endtask

    // kind: 0 good, 1 stuff violation (arg!=0: leave ABORT via idle J's),
    // 2 SE0 after arg stray bits, 3 J after a single SE0, 4 short SYNC.
    task automatic run_packet(input int kind, input int nz, input int arg);
        if (kind != 4) begin
            push_ev(EV_RISE, 8'h00);
            foreach (payload[i]) push_ev(EV_BYTE, payload[i]);
            if (kind != 0) push_ev(EV_ERR, 8'h00);
            push_ev(EV_FALL, 8'h00);
        end
        sync_seq(nz);
        if (kind != 4) foreach (payload[i]) data_byte(payload[i]);
        case (kind)
            0: eop();
            1: begin
                repeat (7 - ones) send_bit(1'b1);
                if (arg != 0) repeat (8) send_line(J);
                else eop();
            end
            2: begin
                repeat (arg) data_bit(1'($urandom_range(1, 0)));
                eop();
            end
            3: begin
                send_line(SE0);
                send_line(J);
                send_line(SE0);
                send_line(J);
            end
            default: repeat (3) send_line(J);
        endcase
        repeat (2) send_line(J);
    endtask

    initial begin
        int kind, nb, nz, arg;
        reset  = 1'b1;
        q      = J;
        strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_rx_data", rx_data, 8'h00);
        check_out("reset_rx_valid", {7'd0, rx_valid}, 8'h00);
        check_out("reset_rx_active", {7'd0, rx_active}, 8'h00);
        check_out("reset_rx_error", {7'd0, rx_error}, 8'h00);
        reset  = 1'b0;
        mon_en = 1'b1;

        repeat (20) send_line(J);
        check_out("idle_rx_data", rx_data, 8'h00);
        check_out("idle_rx_valid", {7'd0, rx_valid}, 8'h00);
        check_out("idle_rx_active", {7'd0, rx_active}, 8'h00);
        check_out("idle_rx_error", {7'd0, rx_error}, 8'h00);

        payload = '{8'hA5};         run_packet(0, 7, 0);
        payload = '{8'hFF};         run_packet(0, 7, 0);
        payload = '{};              run_packet(1, 7, 0);
        payload = '{};              run_packet(2, 7, 3);
        payload = '{};              run_packet(4, 3, 0);
        payload = '{8'hFF, 8'h3F};  run_packet(0, 5, 0);
        payload = '{8'h7E};         run_packet(1, 6, 1);
        payload = '{8'h12};         run_packet(3, 7, 0);

        for (int p = 0; p < 30; p++) begin
            kind = $urandom_range(4, 0);
            nb   = $urandom_range(3, 0);
            nz   = (kind == 4) ? $urandom_range(4, 1) : $urandom_range(7, 5);
            arg  = (kind == 2) ? $urandom_range(7, 1) : $urandom_range(1, 0);
            payload = '{};
            for (int i = 0; i < nb; i++)
                payload.push_back(($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom));
            run_packet(kind, nz, arg);
        end

        // Reset in the middle of the second byte of a good packet.
        push_ev(EV_RISE, 8'h00);
        push_ev(EV_BYTE, 8'hC3);
        push_ev(EV_FALL, 8'h00);
        sync_seq(7);
        data_byte(8'hC3);
        repeat (3) data_bit(1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_out("midreset_rx_data", rx_data, 8'h00);
        check_out("midreset_rx_valid", {7'd0, rx_valid}, 8'h00);
        check_out("midreset_rx_active", {7'd0, rx_active}, 8'h00);
        check_out("midreset_rx_error", {7'd0, rx_error}, 8'h00);
        reset = 1'b0;
        line  = J;
        ones  = 0;
        repeat (4) send_line(J);

        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_events: got %0d outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
